// File: rtl/reset_sequencer.sv
// reset_sequencer: filters PLL lock, releases staged resets in order with a fixed gap, and re-sequences on a soft-reset handshake
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_FILTER = 8,
  parameter int SOFT_HOLD   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  soft_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic                  soft_ack
);
  localparam int CMAX = (STAGE_DELAY > SOFT_HOLD) ? STAGE_DELAY : SOFT_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int LW   = $clog2(LOCK_FILTER + 1);
  localparam int IW   = $clog2(NUM_STAGES + 1);
  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN, S_SOFT} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [LW-1:0] r_lock;
  logic [IW-1:0] r_idx;
  logic          r_arm;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_HOLD;
      r_cnt    <= '0;
      r_lock   <= '0;
      r_idx    <= '0;
      r_arm    <= 1'b1;
      rst_out  <= '1;
      ready    <= 1'b0;
      soft_ack <= 1'b0;
    end else begin
      soft_ack <= 1'b0;
      if (!soft_req) r_arm <= 1'b1;
      if (r_state != S_HOLD && !pll_locked) begin
        r_state <= S_HOLD;
        r_lock  <= '0;
        r_idx   <= '0;
        r_cnt   <= '0;
        rst_out <= '1;
        ready   <= 1'b0;
      end else begin
        case (r_state)
          S_HOLD: begin
            rst_out <= '1;
            ready   <= 1'b0;
            if (!pll_locked) r_lock <= '0;
            else if (r_lock == LW'(LOCK_FILTER - 1)) begin
              r_state <= S_RELEASE;
              r_cnt   <= '0;
              r_idx   <= '0;
            end else r_lock <= r_lock + 1'b1;
          end
          S_RELEASE: begin
            if (r_cnt == CW'(STAGE_DELAY - 1)) begin
              rst_out <= rst_out << 1;
              r_idx   <= r_idx + 1'b1;
              r_cnt   <= '0;
              if (r_idx == IW'(NUM_STAGES - 1)) begin
                r_state <= S_RUN;
                ready   <= 1'b1;
              end
            end else r_cnt <= r_cnt + 1'b1;
          end
          S_RUN: begin
            if (soft_req && r_arm) begin
              r_state <= S_SOFT;
              rst_out <= '1;
              ready   <= 1'b0;
              r_cnt   <= '0;
              r_arm   <= 1'b0;
            end
          end
          S_SOFT: begin
            if (r_cnt == CW'(SOFT_HOLD - 1)) begin
              soft_ack <= 1'b1;
              r_state  <= S_RELEASE;
              r_cnt    <= '0;
              r_idx    <= '0;
            end else r_cnt <= r_cnt + 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks plus an elapsed-time model compared every cycle
module tb_reset_sequencer;
  localparam int NS = 4, SD = 16, LF = 8, SH = 32;
  logic clk = 1'b0, reset, pll_locked, soft_req;
  logic [NS-1:0] rst_out;
  logic ready, soft_ack;
  int cyc = 0, checks = 0, failures = 0, n_ack = 0;
  int m_seq = -1, m_soft = -1, m_run = 0, m_arm = 1, k;
  logic [NS-1:0] m_rst, ones;
  logic m_ready, m_ack;
  int b, e, a0;
  reset_sequencer #(.NUM_STAGES(NS), .STAGE_DELAY(SD), .LOCK_FILTER(LF), .SOFT_HOLD(SH)) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .soft_req(soft_req),
    .rst_out(rst_out), .ready(ready), .soft_ack(soft_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  always @(posedge clk) begin
    cyc++;
    ones = '1;
    m_ack = 1'b0;
    if (reset) begin
      m_seq = -1; m_soft = -1; m_run = 0; m_arm = 1;
    end else begin
      if ((m_seq >= 0 || m_soft >= 0) && !pll_locked) begin
        m_seq = -1; m_soft = -1; m_run = 0;
      end else if (m_seq < 0 && m_soft < 0) begin
        m_run = pll_locked ? m_run + 1 : 0;
        if (m_run == LF) begin m_seq = cyc; m_run = 0; end
      end else if (m_soft >= 0) begin
        if (cyc - m_soft == SH) begin m_ack = 1'b1; m_soft = -1; m_seq = cyc; end
      end else if ((cyc - m_seq) > NS * SD && soft_req && m_arm == 1) begin
        m_soft = cyc; m_seq = -1; m_arm = 0;
      end
      if (!soft_req) m_arm = 1;
    end
    k = (m_seq < 0) ? 0 : (cyc - m_seq) / SD;
    if (k > NS) k = NS;
    m_rst = ones << k;
    m_ready = (m_seq >= 0) && (k == NS);
  end
  always @(negedge clk) if (cyc > 0) begin
    if (soft_ack === 1'b1) n_ack++;
    chk("model_rst_out", 32'(rst_out), 32'(m_rst));
    chk("model_ready", 32'(ready), 32'(m_ready));
    chk("model_soft_ack", 32'(soft_ack), 32'(m_ack));
  end
  initial begin
    reset = 1'b1; pll_locked = 1'b0; soft_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_rst_out", 32'(rst_out), 32'hF);
    chk("reset_ready", 32'(ready), 0);
    chk("reset_ack", 32'(soft_ack), 0);
    reset = 1'b0; pll_locked = 1'b1; b = cyc;
    wait_to(b + 23); chk("t1_e23", 32'(rst_out), 32'hF);
    wait_to(b + 24); chk("t1_e24", 32'(rst_out), 32'hE);
    wait_to(b + 40); chk("t1_e40", 32'(rst_out), 32'hC);
    wait_to(b + 56); chk("t1_e56", 32'(rst_out), 32'h8);
    wait_to(b + 71); chk("t1_e71_ready", 32'(ready), 0);
    wait_to(b + 72); chk("t1_e72", 32'(rst_out), 0); chk("t1_e72_ready", 32'(ready), 1);
    reset = 1'b1; pll_locked = 1'b0; @(negedge clk);
    reset = 1'b0; pll_locked = 1'b1; repeat (5) @(negedge clk);
    pll_locked = 1'b0; @(negedge clk);
    pll_locked = 1'b1; b = cyc;
    wait_to(b + 23); chk("t2_e23", 32'(rst_out), 32'hF); chk("t2_ready", 32'(ready), 0);
    wait_to(b + 24); chk("t2_e24", 32'(rst_out), 32'hE);
    wait_to(b + 72); chk("t2_e72_ready", 32'(ready), 1);
    reset = 1'b1; @(negedge clk);
    reset = 1'b0; b = cyc;
    wait_to(b + 40); chk("t3_e40", 32'(rst_out), 32'hC);
    pll_locked = 1'b0; @(negedge clk);
    chk("t3_loss", 32'(rst_out), 32'hF); chk("t3_loss_ready", 32'(ready), 0);
    pll_locked = 1'b1; b = cyc;
    wait_to(b + 24); chk("t3_e24", 32'(rst_out), 32'hE);
    wait_to(b + 72); chk("t3_e72_ready", 32'(ready), 1);
    soft_req = 1'b1; e = cyc + 1; @(negedge clk);
    soft_req = 1'b0;
    chk("t4_entry", 32'(rst_out), 32'hF); chk("t4_entry_ready", 32'(ready), 0);
    wait_to(e + 31); chk("t4_ack_early", 32'(soft_ack), 0);
    wait_to(e + 32); chk("t4_ack", 32'(soft_ack), 1);
    wait_to(e + 33); chk("t4_ack_late", 32'(soft_ack), 0);
    wait_to(e + 48); chk("t4_e48", 32'(rst_out), 32'hE);
    wait_to(e + 95); chk("t4_e95_ready", 32'(ready), 0);
    wait_to(e + 96); chk("t4_e96_ready", 32'(ready), 1);
    a0 = n_ack; soft_req = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_one_ack", 32'(n_ack - a0), 1); chk("t5_ready", 32'(ready), 1);
    soft_req = 1'b0; @(negedge clk);
    soft_req = 1'b1; e = cyc + 1; @(negedge clk);
    chk("t5_retrigger", 32'(rst_out), 32'hF);
    wait_to(e + 32); chk("t5_ack2", 32'(soft_ack), 1);
    soft_req = 1'b0;
    wait_to(e + 96); chk("t5_ready2", 32'(ready), 1);
    soft_req = 1'b1; e = cyc + 1; @(negedge clk);
    soft_req = 1'b0;
    wait_to(e + 52); chk("t6_mid", 32'(rst_out), 32'hE);
    reset = 1'b1; @(negedge clk);
    chk("t6_rst_mid", 32'(rst_out), 32'hF); chk("t6_rst_mid_ready", 32'(ready), 0);
    reset = 1'b0; b = cyc;
    wait_to(b + 72); chk("t6_relock_ready", 32'(ready), 1);
    soft_req = 1'b1; e = cyc + 1; @(negedge clk);
    soft_req = 1'b0; a0 = n_ack;
    wait_to(e + 31); reset = 1'b1; @(negedge clk);
    chk("t6_ack_suppressed", 32'(soft_ack), 0); chk("t6_ack_rst", 32'(rst_out), 32'hF);
    reset = 1'b0; b = cyc;
    wait_to(b + 72); chk("t6_ready", 32'(ready), 1);
    soft_req = 1'b1; e = cyc + 1; @(negedge clk);
    soft_req = 1'b0; a0 = n_ack;
    wait_to(e + 10); pll_locked = 1'b0; @(negedge clk);
    chk("t7_soft_loss", 32'(rst_out), 32'hF);
    pll_locked = 1'b1; b = cyc;
    wait_to(e + 40); chk("t7_no_ack", 32'(n_ack - a0), 0);
    wait_to(b + 72); chk("t7_ready", 32'(ready), 1);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Staged reset controller for the OPL3 synth top level. It takes the already-synchronized system reset and the PLL lock flag, filters lock, and releases per-subsystem resets in a fixed order with a programmable gap. Example order: clock-enable generators, register interface, operator pipeline, audio DAC/I2S. It also provides a soft-reset handshake so the host interface can re-sequence the synth core without a PLL or board reset.

Parameters:
NUM_STAGES, 4, number of staged reset outputs (1..8)
STAGE_DELAY, 16, cycles between successive stage releases (>=1)
LOCK_FILTER, 8, consecutive high samples of pll_locked required before sequencing (>=1)
SOFT_HOLD, 32, cycles all stage resets are held during a soft reset (>=1)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset (driven from the reset synchronizer)
pll_locked  in  1  PLL lock flag, already synchronized to clk
soft_req  in  1  level soft-reset request from the host interface
rst_out  out  NUM_STAGES  per-stage active-high resets; bit 0 is released first
ready  out  1  high when all stages are out of reset
soft_ack  out  1  one-cycle pulse when a soft-reset hold completes

Behaviour:
- Interface: one clock `clk`. `reset` is synchronous and active-high. All state is updated on the rising edge of clk. No asynchronous paths.
- Reset value of outputs while reset=1:
  - rst_out all ones, ready=0, soft_ack=0.
  - state=HOLD, counters=0, stage index=0, soft arm flag=1.
- Counters are sized with $clog2(max+1). The stage index is $clog2(NUM_STAGES+1) bits.
- States: HOLD, RELEASE, RUN, SOFT.
- HOLD:
  - rst_out all ones; the lock counter increments while pll_locked=1 and clears to 0 on any low sample.
  - On the LOCK_FILTER-th consecutive high sample, go to RELEASE with cnt=0 and idx=0.
- RELEASE:
  - cnt counts 0..STAGE_DELAY-1. At terminal count: clear rst_out[idx], idx++, cnt=0.
  - rst_out[k] falls on edge LOCK_FILTER+(k+1)*STAGE_DELAY, counting from the first high lock sample as edge 1.
  - Bits are released strictly in ascending order and never reassert except via HOLD/SOFT.
  - When the last stage is released, go to RUN. ready rises on the same edge as rst_out[NUM_STAGES-1] falls.
- RUN:
  - rst_out all zero, ready=1.
  - If soft_req=1 and arm=1, go to SOFT: rst_out all ones and ready=0 on that edge, cnt=0, arm=0.
- SOFT:
  - Hold all resets for SOFT_HOLD cycles.
  - soft_ack is high for exactly one cycle, on the edge SOFT_HOLD after entry.
  - The same edge enters RELEASE with idx=0, cnt=0. The lock filter is not rerun.
- Soft handshake:
  - soft_req is level-sensitive.
  - arm re-sets only when soft_req is sampled low. A request held high after ack does not retrigger.
  - soft_req is ignored (not latched) in HOLD, RELEASE and SOFT.
- Lock loss:
  - pll_locked=0 in RELEASE, RUN or SOFT goes to HOLD on the next edge: rst_out all ones, ready=0, lock counter=0, idx=0.
  - A pending soft_ack is suppressed.
  - Lock loss has priority over soft_req and over terminal counts on the same edge.
- reset=1 mid-sequence overrides everything, including a soft_ack due on that edge.
- NUM_STAGES=1 is legal: a single release after STAGE_DELAY cycles.

Test Plan:
1. Power-on, defaults: reset high 5 cycles, then pll_locked=1 from edge 1. rst_out goes 1111 -> 1110@24 -> 1100@40 -> 1000@56 -> 0000@72; ready=1@72.
2. Lock glitch: pll_locked high for 5 edges, low for 1, then high. Sequence restarts; rst_out[0] falls 24 edges after the re-rise; ready stays 0 throughout.
3. Lock loss mid-release: drop pll_locked after rst_out=1100. Next edge rst_out=1111, ready=0; the full 8+16k timing repeats after re-lock.
4. Soft reset in RUN: pulse soft_req for 1 cycle at edge E. rst_out=1111 at E; soft_ack high for one cycle at E+32; rst_out[k] falls at E+32+16(k+1); ready at E+96.
5. soft_req held high for 200 cycles: exactly one soft_ack. Then drop for 1 cycle and raise again: a second soft sequence starts.
6. Synchronous reset asserted mid-RELEASE and on the soft_ack edge: outputs return to reset values on that edge, with no soft_ack pulse.
